// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch front end.
// Struct widths follow the package widths; the top keeps XLEN/INST_W at these values.
package fetch_pkg;

  localparam int FETCH_XLEN            = 32;
  localparam int FETCH_INST_W          = 32;
  localparam int FETCH_MAX_OUTSTANDING = 2;
  localparam int CNT_W                 = $clog2(FETCH_MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic                  epoch;
  } fetch_tag_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0]   pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_out_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of an arbitrary packed type with flush; push and pop may
// coincide at any occupancy, and the head reads as zero while empty.
module fetch_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2,
  parameter int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;
  logic          push_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  assign empty  = (count_r == {CW{1'b0}});
  assign full   = (count_r == CW'(DEPTH));
  assign count  = count_r;
  assign pop_s  = pop & ~empty;
  assign push_s = push & (~full | pop_s);
  assign head   = empty ? T'(0) : mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; flush drops contents including a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= T'(0);
      end
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule

// File: rtl/fetch_unit_checker.sv
// Simulation checks on fetch credit accounting: occupancy bound and no FIFO overflow.
module fetch_unit_checker #(
  parameter int MAX = 2,
  parameter int CW  = 2
) (
  input logic        clk,
  input logic        rst,
  input logic [CW:0] occupancy,
  input logic        req_fire,
  input logic        tag_full,
  input logic        buf_push,
  input logic        buf_pop,
  input logic        buf_full
);

  a_occupancy_bound: assert property (@(posedge clk) disable iff (!rst)
    occupancy <= (CW + 1)'(MAX));

  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(tag_full && req_fire));

  a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(buf_full && buf_push && !buf_pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem requests,
// in-order responses tagged with an epoch so redirects discard stale returns.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = FETCH_XLEN,
  parameter int              INST_W          = FETCH_INST_W,
  parameter logic [XLEN-1:0] RESET_PC        = {XLEN{1'b0}},
  parameter int              PC_STEP         = 4,
  parameter int              MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);

  logic [XLEN-1:0] pc_r;
  logic            epoch_r;
  fetch_tag_t      tag_push_s;
  fetch_tag_t      tag_head_s;
  fetch_out_t      buf_push_data_s;
  fetch_out_t      buf_head_s;
  logic [CW-1:0]   inflight_cnt_s;
  logic [CW-1:0]   buf_cnt_s;
  logic [CW:0]     occupancy_s;
  logic            tag_full_s;
  logic            tag_empty_s;
  logic            buf_full_s;
  logic            buf_empty_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            rsp_fire_s;
  logic            buf_push_s;
  logic            out_pop_s;

  // Stale in-flight entries keep holding credit until their responses return.
  assign occupancy_s     = {1'b0, inflight_cnt_s} + {1'b0, buf_cnt_s};
  assign req_valid_s     = rst & ~redirect_valid & (occupancy_s < (CW + 1)'(MAX_OUTSTANDING));
  assign req_fire_s      = req_valid_s & imem_req_ready;
  assign rsp_fire_s      = imem_rsp_valid & ~tag_empty_s;
  assign buf_push_s      = rsp_fire_s & (tag_head_s.epoch == epoch_r);
  assign out_pop_s       = ~buf_empty_s & out_ready;
  assign tag_push_s      = '{pc: pc_r, epoch: epoch_r};
  assign buf_push_data_s = '{pc: tag_head_s.pc, inst: imem_rsp_data};

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign out_valid      = ~buf_empty_s;
  assign out_pc         = buf_head_s.pc;
  assign out_inst       = buf_head_s.inst;

  // PC and epoch: redirect wins over sequential advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r    <= RESET_PC;
      epoch_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r    <= redirect_pc;
      epoch_r <= ~epoch_r;
    end else if (req_fire_s) begin
      pc_r    <= pc_r + XLEN'(PC_STEP);
    end
  end

  fetch_fifo #(
    .T     (fetch_tag_t),
    .DEPTH (MAX_OUTSTANDING),
    .CW    (CW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire_s),
    .push_data (tag_push_s),
    .pop       (rsp_fire_s),
    .head      (tag_head_s),
    .full      (tag_full_s),
    .empty     (tag_empty_s),
    .count     (inflight_cnt_s)
  );

  fetch_fifo #(
    .T     (fetch_out_t),
    .DEPTH (MAX_OUTSTANDING),
    .CW    (CW)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (buf_push_s),
    .push_data (buf_push_data_s),
    .pop       (out_pop_s),
    .head      (buf_head_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s),
    .count     (buf_cnt_s)
  );

  fetch_unit_checker #(
    .MAX (MAX_OUTSTANDING),
    .CW  (CW)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .occupancy (occupancy_s),
    .req_fire  (req_fire_s),
    .tag_full  (tag_full_s),
    .buf_push  (buf_push_s),
    .buf_pop   (out_pop_s),
    .buf_full  (buf_full_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with configurable latency, credit and
// epoch model, and an in-order scoreboard of {pc, inst} pairs expected at the output.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          MAX    = 2;

  typedef struct { logic [31:0] addr; int due; int gen; logic epoch; } mem_ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] target; logic [31:0] next_addr; } redir_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  mem_ent_t    mem_q[$];
  exp_t        exp_q[$];
  redir_vec_t  vecs[3];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gen = 0;
  int          infl = 0;
  int          bufc = 0;
  int          fires = 0;
  logic        epoch_m = 1'b0;
  logic [31:0] pc_m = RST_PC;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // One clock: present memory response, sample at negedge, update model, advance.
  task automatic tick();
    mem_ent_t e;
    exp_t     x;
    logic     rsp_now;
    logic     exp_rv;
    rsp_now        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? inst_of(mem_q[0].addr) : 32'h0;
    @(negedge clk);
    if (rsp_now) e = mem_q.pop_front();
    if (!rst) begin
      chk("req_valid_in_reset", {31'b0, imem_req_valid}, 32'h0);
      exp_q.delete();
      infl = 0; bufc = 0; pc_m = RST_PC; epoch_m = 1'b0; gen++;
    end else begin
      exp_rv = !redirect_valid && ((infl + bufc) < MAX);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      chk("out_valid", {31'b0, out_valid}, {31'b0, bufc != 0});
      if (bufc != 0 && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output @cycle %0d: got pc %h expected none", cyc, out_pc);
        end else begin
          x = exp_q.pop_front();
          chk("out_pc", out_pc, x.pc);
          chk("out_inst", out_inst, x.inst);
        end
        bufc--;
      end
      if (rsp_now && e.gen == gen) begin
        infl--;
        if (e.epoch == epoch_m && !redirect_valid) bufc++;
      end
      if (exp_rv && imem_req_ready) begin
        chk("req_addr", imem_req_addr, pc_m);
        exp_q.push_back('{pc: pc_m, inst: inst_of(pc_m)});
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat, gen: gen, epoch: epoch_m});
        infl++; fires++;
        pc_m = pc_m + 32'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        bufc = 0; epoch_m = ~epoch_m; pc_m = redirect_pc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name);
    int n;
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || mem_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_%s: got %0d outputs pending, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] start_pc;
    vecs[0] = '{target: 32'h0000_0100, next_addr: 32'h0000_0104};
    vecs[1] = '{target: 32'hFFFF_FFFC, next_addr: 32'h0000_0000};
    vecs[2] = '{target: 32'h8000_0000, next_addr: 32'h8000_0004};

    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; out_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_req_addr", imem_req_addr, RST_PC);

    // Streaming with 1-cycle memory, crossing the address wrap from RESET_PC.
    imem_req_ready = 1'b1;
    repeat (20) tick();
    drain("stream");

    // Decode stalled: only MAX requests go out, head held.
    start_pc = pc_m;
    out_ready = 1'b0; imem_req_ready = 1'b1; fires = 0;
    repeat (10) tick();
    chk("stall_fires", fires, 32'd2);
    chk("stall_out_valid", {31'b0, out_valid}, 32'h1);
    chk("stall_out_pc", out_pc, start_pc);
    out_ready = 1'b1;
    repeat (6) tick();
    drain("stall");

    // Redirect vectors: in-flight responses dropped, new stream from target.
    for (int i = 0; i < 3; i++) begin
      imem_req_ready = 1'b1; out_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1; redirect_pc = vecs[i].target;
      tick();
      redirect_valid = 1'b0;
      chk("redir_addr", imem_req_addr, vecs[i].target);
      chk("redir_out_valid", {31'b0, out_valid}, 32'h0);
      fires = 0; n = 0;
      while (fires == 0 && n < 20) begin
        tick();
        n++;
      end
      chk("redir_fired", {31'b0, fires != 0}, 32'h1);
      chk("redir_next_addr", imem_req_addr, vecs[i].next_addr);
      repeat (3) tick();
    end
    drain("redirect");

    // Random request/decode backpressure with 3-cycle memory.
    lat = 3;
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = 1'($urandom_range(0, 1));
      tick();
    end
    drain("random");

    // Reset mid-stream with requests in flight; late responses must be ignored.
    imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    rst = 1'b0; imem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_req_addr", imem_req_addr, RST_PC);
    repeat (5) tick();
    imem_req_ready = 1'b1;
    repeat (10) tick();
    drain("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
